// File: rtl/seg_scan.sv
// Eight-digit seven-segment scan: BCD decode, decimal points, per-digit blink, power blanking.
// Latency: 1 cycle, inputs to registered anodes/cnodes. Free-running scan with no backpressure.
module seg_scan #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic        clk_src,
  input  logic        reset,
  input  logic        power,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  anodes,
  output logic [7:0]  cnodes,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    anodes_q, anodes_d;
  logic [7:0]    cnodes_q, cnodes_d;
  logic          frame_done_q, frame_done_d;

  logic          presc_wrap;
  logic          frame_wrap;
  logic          bcnt_wrap;
  logic          blank;
  logic [4:0]    nib_lsb;
  logic [3:0]    nib;
  logic [6:0]    seg;

  assign presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_wrap = presc_wrap && (idx_q == 3'd7);
  assign bcnt_wrap  = (bcnt_q == BW'(BLINK_FRAMES - 1));

  // Active-low segments {g,f,e,d,c,b,a}; A shows a dash, B..F are blank.
  always_comb begin
    nib_lsb = {idx_q, 2'b00};
    nib     = digits[nib_lsb +: 4];
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h3F;
      default: seg = 7'h7F;
    endcase
  end

  // Phase only flips on the frame-wrap edge, so a dwell is never split.
  always_comb begin
    presc_d      = '0;
    idx_d        = '0;
    bcnt_d       = '0;
    phase_d      = 1'b0;
    frame_done_d = 1'b0;
    anodes_d     = 8'hFF;
    cnodes_d     = 8'hFF;
    blank        = blink_mask[idx_q] & phase_q;
    if (power) begin
      presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
      idx_d        = presc_wrap ? idx_q + 3'd1 : idx_q;
      bcnt_d       = bcnt_q;
      phase_d      = phase_q;
      frame_done_d = frame_wrap;
      if (frame_wrap) begin
        bcnt_d  = bcnt_wrap ? '0 : bcnt_q + BW'(1);
        phase_d = phase_q ^ bcnt_wrap;
      end
      if (!blank) begin
        anodes_d = ~(8'b1 << idx_q);
        cnodes_d = {~dp_mask[idx_q], seg};
      end
    end
  end

  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      anodes_q     <= 8'hFF;
      cnodes_q     <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      anodes_q     <= anodes_d;
      cnodes_q     <= cnodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes     = anodes_q;
  assign cnodes     = cnodes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed scenarios plus randomized inputs against an edge-count model.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk_src = 1'b0;
  logic        reset = 1'b0;
  logic        power = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  anodes;
  logic [7:0]  cnodes;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk_src   (clk_src),
    .reset     (reset),
    .power     (power),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blink_mask(blink_mask),
    .anodes    (anodes),
    .cnodes    (cnodes),
    .frame_done(frame_done)
  );

  always #5 clk_src = ~clk_src;

  // n_edge counts powered edges since reset release / power-on.
  task automatic cyc();
    @(posedge clk_src);
    if (reset && power) n_edge = n_edge + 1;
    else n_edge = 0;
    @(negedge clk_src);
  endtask

  // Expected {anodes, cnodes, frame_done} after powered edge n with the given inputs.
  function automatic logic [16:0] model(input int n, input logic [31:0] d,
                                        input logic [7:0] dp, input logic [7:0] bm);
    int k, frame, ph;
    logic [3:0] nib;
    logic [7:0] an, cn;
    logic fd;
    if (n == 0) return {8'hFF, 8'hFF, 1'b0};
    k     = ((n - 1) / SD) % 8;
    frame = (n - 1) / (8 * SD);
    ph    = (frame / BF) % 2;
    nib   = 4'((d >> (4 * k)) & 32'hF);
    cn    = seg_tab[nib];
    if (dp[k]) cn[7] = 1'b0;
    an    = ~(8'(1) << k);
    if (bm[k] && ph == 1) begin
      an = 8'hFF;
      cn = 8'hFF;
    end
    fd = ((n % (8 * SD)) == 0);
    return {an, cn, fd};
  endfunction

  task automatic restart();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    reset = 1'b0; power = 1'b1; digits = 32'h12345678; dp_mask = '0; blink_mask = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({anodes, cnodes, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold: got an=%h cn=%h fd=%b want FF FF 0", anodes, cnodes, frame_done);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      exp = model(n_edge, digits, dp_mask, blink_mask);
      checks++;
      if ({anodes, cnodes, frame_done} !== exp) begin
        errors++;
        $display("FAIL scan edge %0d: got an=%h cn=%h fd=%b want an=%h cn=%h fd=%b",
                 n_edge, anodes, cnodes, frame_done, exp[16:9], exp[8:1], exp[0]);
      end
      if (n_edge == 1 || n_edge == 5 || n_edge == 29) begin
        checks++;
        if (!((n_edge == 1  && anodes === 8'hFE && cnodes === 8'h80) ||
              (n_edge == 5  && anodes === 8'hFD && cnodes === 8'hF8) ||
              (n_edge == 29 && anodes === 8'h7F && cnodes === 8'hF9))) begin
          errors++;
          $display("FAIL scan_fixed edge %0d: got an=%h cn=%h", n_edge, anodes, cnodes);
        end
      end
      if (n_edge == 32 || n_edge == 33) begin
        checks++;
        if (frame_done !== (n_edge == 32)) begin
          errors++;
          $display("FAIL frame_done edge %0d: got %b want %b", n_edge, frame_done, n_edge == 32);
        end
      end
    end
  endtask

  task automatic test_decode();
    bit found;
    digits = '0; dp_mask = '0; blink_mask = '0;
    for (int v = 0; v < 16; v++) begin
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (n_edge % (8 * SD) == 0) found = 1;
        else cyc();
      end
      digits = {28'h0, 4'(v)};
      cyc();
      checks++;
      if (!found || anodes !== 8'hFE || cnodes !== seg_tab[v]) begin
        errors++;
        $display("FAIL decode nib %h: got an=%h cn=%h want an=FE cn=%h", v, anodes, cnodes, seg_tab[v]);
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] want;
    int k;
    digits = '0; dp_mask = 8'h04; blink_mask = '0;
    for (int i = 0; i < 8 * SD; i++) begin
      cyc();
      k = ((n_edge - 1) / SD) % 8;
      want = (k == 2) ? 8'h40 : 8'hC0;
      checks++;
      if (cnodes !== want || anodes !== ~(8'(1) << k)) begin
        errors++;
        $display("FAIL dp digit %0d: got an=%h cn=%h want cn=%h", k, anodes, cnodes, want);
      end
    end
  endtask

  task automatic test_blink();
    int k, frame;
    bit hidden;
    digits = 32'h87654321; dp_mask = '0; blink_mask = 8'h03;
    restart();
    for (int i = 0; i < 6 * 8 * SD; i++) begin
      cyc();
      k = ((n_edge - 1) / SD) % 8;
      frame = (n_edge - 1) / (8 * SD);
      hidden = (k < 2) && (frame == 2 || frame == 3);
      checks++;
      if (hidden ? (anodes !== 8'hFF || cnodes !== 8'hFF)
                 : (anodes !== ~(8'(1) << k) || cnodes !== seg_tab[(digits >> (4 * k)) & 32'hF])) begin
        errors++;
        $display("FAIL blink frame %0d digit %0d: got an=%h cn=%h hidden=%b", frame, k, anodes, cnodes, hidden);
      end
    end
  endtask

  task automatic test_power();
    digits = 32'h12345678; dp_mask = '0; blink_mask = '0;
    restart();
    for (int i = 0; i < 22; i++) cyc();
    power = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({anodes, cnodes, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL power_off cyc %0d: got an=%h cn=%h fd=%b want FF FF 0", i, anodes, cnodes, frame_done);
      end
    end
    power = 1'b1;
    cyc();
    checks++;
    if (anodes !== 8'hFE || cnodes !== 8'h80) begin
      errors++;
      $display("FAIL power_on: got an=%h cn=%h want FE 80", anodes, cnodes);
    end
  endtask

  task automatic test_async_reset();
    digits = 32'h12345678; dp_mask = 8'hFF; blink_mask = '0;
    restart();
    for (int i = 0; i < 14; i++) cyc();
    checks++;
    if (anodes !== 8'hF7) begin
      errors++;
      $display("FAIL pre_async: got an=%h want F7", anodes);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (anodes !== 8'hFF || cnodes !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got an=%h cn=%h want FF FF", anodes, cnodes);
    end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (anodes !== 8'hFE || cnodes !== 8'h00) begin
      errors++;
      $display("FAIL async_restart: got an=%h cn=%h want FE 00", anodes, cnodes);
    end
  endtask

  task automatic test_random();
    logic [16:0] exp;
    restart();
    for (int i = 0; i < 1500; i++) begin
      digits     = $urandom;
      dp_mask    = 8'($urandom);
      blink_mask = 8'($urandom);
      power      = ($urandom_range(0, 199) != 0);
      cyc();
      exp = model(n_edge, digits, dp_mask, blink_mask);
      checks++;
      if ({anodes, cnodes, frame_done} !== exp) begin
        errors++;
        $display("FAIL random cyc %0d edge %0d: got an=%h cn=%h fd=%b want an=%h cn=%h fd=%b",
                 i, n_edge, anodes, cnodes, frame_done, exp[16:9], exp[8:1], exp[0]);
      end
    end
    power = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_dp();
    test_blink();
    test_power();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Display-scan stage downstream of the clock core: it takes the eight packed BCD digits the time-keeping logic produces and time-multiplexes them onto the eight-digit seven-segment display through `anodes`/`cnodes`. It owns digit dwell timing, BCD-to-segment decode, decimal points, per-digit blinking (used for the set-time and alarm indications) and power-off blanking.

## Interface

Parameters:

- `SCAN_DIV`, default 4: clock cycles each digit is driven. Legal range 2..2^20; top level overrides it for hardware.
- `BLINK_FRAMES`, default 2: full 8-digit frames per blink half-period. Legal range 1..255.

Ports:

- `clk_src`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `power`  in  1  1 = display on; 0 = blank and hold scan counters cleared.
- `digits`  in  32  eight BCD nibbles; digit k = `digits[4k+3:4k]`; digit 0 is rightmost.
- `dp_mask`  in  8  bit k = 1 lights the decimal point of digit k.
- `blink_mask`  in  8  bit k = 1 makes digit k blink.
- `anodes`  out  8  active-low one-hot digit select; bit k = digit k.
- `cnodes`  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- `frame_done`  out  1  one-cycle pulse per completed frame.

## Operation

- State:
  - `presc` counts 0..SCAN_DIV-1.
  - `idx` is 3 bits, 0..7, and wraps 7→0.
  - `bcnt` counts 0..BLINK_FRAMES-1.
  - `phase` is the blink phase, 0 = visible.
- Reset (`reset`=0, asynchronous): `presc`=0, `idx`=0, `bcnt`=0, `phase`=0, `anodes`=8'hFF, `cnodes`=8'hFF, `frame_done`=0.
- Each edge with `power`=1:
  - `presc` increments.
  - At `presc`=SCAN_DIV-1, `presc` returns to 0 and `idx` increments.
  - When `idx` goes 7→0, `bcnt` increments. At `bcnt`=BLINK_FRAMES-1, `bcnt` returns to 0 and `phase` toggles.
- Each edge with `power`=0:
  - `presc`, `idx`, `bcnt` and `phase` are cleared synchronously.
  - `anodes`=8'hFF, `cnodes`=8'hFF, `frame_done`=0.
- Output register, loaded each edge with `power`=1 from the pre-edge `idx` and the current inputs:
  - If `blink_mask[idx]`=1 and `phase`=1: `anodes`=8'hFF and `cnodes`=8'hFF (digit blanked).
  - Otherwise `anodes`=~(8'b1 << idx).
  - `cnodes[6:0]` = decode of nibble `idx`; `cnodes[7]` = ~`dp_mask[idx]`.
- Decode of `cnodes`, with dp off:

  | Nibble | `cnodes` |
  |---|---|
  | 0 | C0 |
  | 1 | F9 |
  | 2 | A4 |
  | 3 | B0 |
  | 4 | 99 |
  | 5 | 92 |
  | 6 | 82 |
  | 7 | F8 |
  | 8 | 80 |
  | 9 | 90 |
  | A ('-', segment g only) | BF |
  | B..F (blank) | FF |

- A lit dp clears bit 7 of the value above. A blank nibble (B..F) still lights its dp if `dp_mask` is set.
- `frame_done` is registered and is 1 for exactly the cycle after the edge where `idx` wraps 7→0.

## Timing

- All outputs are registered. Input-to-output latency is 1 cycle: a change to `digits`, `dp_mask` or `blink_mask` appears on the next edge for the digit currently selected.
- The first edge after `reset` deasserts (with `power`=1) drives digit 0.
- Each digit is driven for exactly SCAN_DIV consecutive cycles. Frame period = 8·SCAN_DIV cycles.
- With SCAN_DIV=4, digit k is output on edges 4k+1..4k+4 after reset release, modulo 32.
- `frame_done` period = 8·SCAN_DIV cycles. Its first pulse follows edge 32 after release for SCAN_DIV=4.
- Blink half-period = BLINK_FRAMES·8·SCAN_DIV cycles. Phase changes only on a frame boundary, so a digit is never half-blanked within its dwell.
- Power-on restarts the sequence exactly as reset release does: the first edge with `power`=1 drives digit 0.
- `power` falling forces blank on the next edge. `reset` asserted mid-dwell blanks immediately, without waiting for a clock.
- Simultaneous `presc` terminal count and `idx` 7→0 wrap: the frame counters advance on that same edge. `frame_done` and the blink update never slip a frame.

## Test plan

1. Reset and scan. Stimulus: `reset` low for 3 cycles, then high; `power`=1; `digits`=32'h12345678; masks 0. Required:
   - `anodes`=FF and `cnodes`=FF during reset.
   - Edges 1-4 give `anodes`=FE, `cnodes`=80 ('8').
   - Edges 5-8 give `anodes`=FD, `cnodes`=F8 ('7').
   - Edges 29-32 give `anodes`=7F, `cnodes`=F9 ('1').
   - `frame_done` is high for one cycle after edge 32.
2. Decode sweep. Stimulus: step digit 0 through 0..F. Required: `cnodes` follows the decode list on the next digit-0 dwell; nibbles B..F give FF and A gives BF.
3. Decimal point. Stimulus: `dp_mask`=8'h04, `digits`=0. Required: digit 2 dwell gives `cnodes`=40; every other digit gives C0.
4. Blink. Stimulus: `blink_mask`=8'h03, BLINK_FRAMES=2. Required:
   - Frames 0-1: digits 0 and 1 are visible.
   - Frames 2-3: digits 0 and 1 give `anodes`=FF and `cnodes`=FF.
   - Frames 4-5: digits 0 and 1 are visible again.
   - Digits 2-7 are never blanked.
5. Power cycle. Stimulus: `power`=0 mid-digit-5 for 10 cycles, then `power`=1. Required: `anodes`=FF and `cnodes`=FF from the next edge, no `frame_done`; the first edge after re-enable drives `anodes`=FE.
6. Async reset mid-dwell. Stimulus: assert `reset` between clock edges during digit 3. Required: `anodes` and `cnodes` go to FF before the next edge; the scan restarts at digit 0 after release.
